m68k_sram_arbiter: RTL

M68K_SRAM_ARBITER -- requirements
Module: m68k_sram_arbiter

---
 rtl/m68k_soc_pkg.sv | 21 ++
 rtl/m68k_arb_pick.sv | 20 ++
 rtl/m68k_sram_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/m68k_soc_pkg.sv
// Shared definitions for the M68K SoC SRAM arbiter: FSM encoding, port indices, defaults.
// Latency: none (declarations only).
// Backpressure: not applicable.
package m68k_soc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } arb_state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   localparam int DEFAULT_STARVE_LIMIT = 8;

   function automatic logic [1:0] port_onehot(input logic port);
      return port ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/m68k_arb_pick.sv
// Two-port winner selection: the single requester wins, or on a tie the preferred port.
// Latency: purely combinational.
// Backpressure: none; the caller samples the result only in IDLE.
module m68k_arb_pick
   import m68k_soc_pkg::*;
(
   input  logic [1:0] req,
   input  logic       prefer_dma,
   output logic       winner
);

   // Port 1 wins when it is alone or when the tie-break favours it.
   always_comb begin
      winner = PORT_CPU;
      if (req[1] && (!req[0] || prefer_dma)) begin
         winner = PORT_DMA;
      end
   end

endmodule

// File: rtl/m68k_sram_arbiter.sv
// Two-master arbiter in front of sram_controller_unified (CPU port 0, DMA/video port 1).
// Latency: mem_valid the cycle after the request is seen idle, ready the cycle after mem_ready.
// Backpressure: masters hold valid until their one-cycle ready; M68K_ARB_ROUND_ROBIN_EN selects round-robin ties.
module m68k_sram_arbiter
   import m68k_soc_pkg::*;
#(
   parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        m0_valid,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  grant,
   output logic        busy
);

   arb_state_t state;
   logic       owner;
   logic [1:0] req;
   logic       win;
   logic       prefer_dma;
   logic       arbitrate;

   assign req       = {m1_valid, m0_valid};
   assign arbitrate = (state == ST_IDLE) && (|req);

`ifdef M68K_ARB_ROUND_ROBIN_EN
   logic rr_ptr;

   assign prefer_dma = rr_ptr;

   // Hand the next tie to whichever port was not granted this time.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rr_ptr <= 1'b0;
      end else if (arbitrate) begin
         rr_ptr <= ~win;
      end
   end
`else
   localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

   logic [7:0] starve_cnt;

   assign prefer_dma = (starve_cnt == STARVE_MAX);

   // Count consecutive arbitrations port 1 lost; granting port 1 clears the count.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         starve_cnt <= 8'd0;
      end else if (arbitrate) begin
         if (win == PORT_DMA) begin
            starve_cnt <= 8'd0;
         end else if (req[1] && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 8'd1;
         end
      end
   end
`endif

   m68k_arb_pick u_pick (
      .req        (req),
      .prefer_dma (prefer_dma),
      .winner     (win)
   );

   // Transaction FSM; memory-side and master-side outputs are all registered here.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         owner     <= PORT_CPU;
         mem_valid <= 1'b0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
         mem_wstrb <= 4'd0;
         m0_ready  <= 1'b0;
         m1_ready  <= 1'b0;
         m0_rdata  <= 32'd0;
         m1_rdata  <= 32'd0;
         grant     <= 2'b00;
         busy      <= 1'b0;
      end else begin
         m0_ready <= 1'b0;
         m1_ready <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (|req) begin
                  // Latch the winner's request so later changes on its bus are ignored.
                  owner     <= win;
                  mem_addr  <= (win == PORT_DMA) ? m1_addr  : m0_addr;
                  mem_wdata <= (win == PORT_DMA) ? m1_wdata : m0_wdata;
                  mem_wstrb <= (win == PORT_DMA) ? m1_wstrb : m0_wstrb;
                  mem_valid <= 1'b1;
                  grant     <= port_onehot(win);
                  busy      <= 1'b1;
                  state     <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  state     <= ST_DONE;
                  if (owner == PORT_DMA) begin
                     m1_ready <= 1'b1;
                     if (mem_wstrb == 4'd0) begin
                        m1_rdata <= mem_rdata;
                     end
                  end else begin
                     m0_ready <= 1'b1;
                     if (mem_wstrb == 4'd0) begin
                        m0_rdata <= mem_rdata;
                     end
                  end
               end
            end
            ST_DONE: begin
               grant <= 2'b00;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               mem_valid <= 1'b0;
               grant     <= 2'b00;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
